trng_com_rx: RTL and testbench

Serial receiver for the host-to-board direction of the TRNG serial link, the counterpart of the `trng_com` transmitter. It deserialises 8N1 asynchronous frames from `i_serial_data` and presents each byte through a one-entry valid/read buffer to the command logic in `trng_top`. It reports framing errors and overruns, and drives the `_n` flow-control line back to the host so the host holds off while the buffer is occupied.

---
 rtl/trng_com_rx.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_trng_com_rx.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_com_rx.sv
`default_nettype none
// ============================================================================
// Module   : trng_com_rx
// Purpose  : 8N1 asynchronous serial receiver for the host-to-board direction
//            of the TRNG serial link. Each received byte is held in a
//            one-entry valid/read buffer for the command logic. Framing
//            errors are pulsed, dropped bytes are flagged sticky, and a
//            registered active-low clear-to-send tells the host to hold off
//            while the buffer is occupied.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLKS_PER_BIT    clock cycles per serial bit (8..65535)
// Ports
//   i_clk           system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_serial_data   serial line from host, idles high
//   i_read          consumer takes o_dat this cycle (ignored when !o_valid)
//   o_dat           last received byte
//   o_valid         o_dat holds an unread byte
//   o_frame_err     one-cycle pulse: stop bit sampled low
//   o_overrun       sticky: a byte was dropped because the buffer was full
//   o_serial_cts_n  flow control to host, 1 = hold off, 0 = may send
// ============================================================================
module trng_com_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_serial_data,
  input  logic       i_read,
  output logic [7:0] o_dat,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_serial_cts_n
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int BCNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF   = CLKS_PER_BIT / 2;

  // Sample points around mid-bit; the bit is decided at the last of them.
  localparam logic [BCNT_W-1:0] SAMP_EARLY = BCNT_W'(HALF - 1);
  localparam logic [BCNT_W-1:0] SAMP_MID   = BCNT_W'(HALF);
  localparam logic [BCNT_W-1:0] SAMP_LATE  = BCNT_W'(HALF + 1);
  localparam logic [BCNT_W-1:0] BIT_LAST   = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic              sync_meta;
  logic              rx;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W-1:0] bcnt_next;
  logic [2:0]        bidx;
  logic [2:0]        bidx_next;

  logic [1:0]        vote;       // [1] = sample at H-1, [0] = sample at H
  logic              vote_bit;
  logic              decide;
  logic              wrap;

  logic [7:0]        shreg;

  logic              shift_en;
  logic              byte_done;
  logic              frame_bad;
  logic              take;
  logic              load;
  logic              drop;
  logic              valid_next;
  logic              overrun_next;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; idles high so a reset never looks like a start bit
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_meta <= 1'b1;
      rx        <= 1'b1;
    end else begin
      sync_meta <= i_serial_data;
      rx        <= sync_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Bit-timing decodes and majority vote
  // --------------------------------------------------------------------------
  // The third sample of the vote is the live rx value at the decision point,
  // so only the first two samples need storage.
  assign decide   = (bcnt == SAMP_LATE);
  assign wrap     = (bcnt == BIT_LAST);
  assign vote_bit = (vote[1] & vote[0]) | (vote[1] & rx) | (vote[0] & rx);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vote <= 2'b11;
    end else begin
      if (bcnt == SAMP_EARLY) begin
        vote[1] <= rx;
      end
      if (bcnt == SAMP_MID) begin
        vote[0] <= rx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register (also holds the bit counter and bit index)
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      bcnt  <= '0;
      bidx  <= 3'd0;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
      bidx  <= bidx_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    bidx_next  = bidx;

    case (state)
      ST_IDLE: begin
        bcnt_next = '0;
        bidx_next = 3'd0;
        if (!rx) begin
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (decide && vote_bit) begin
          // Start bit did not survive the vote: treat it as a glitch.
          state_next = ST_IDLE;
          bcnt_next  = '0;
        end else if (wrap) begin
          state_next = ST_DATA;
          bcnt_next  = '0;
          bidx_next  = 3'd0;
        end else begin
          bcnt_next = bcnt + BCNT_ONE;
        end
      end

      ST_DATA: begin
        if (wrap) begin
          bcnt_next = '0;
          bidx_next = bidx + 3'd1;
          if (bidx == 3'd7) begin
            state_next = ST_STOP;
          end
        end else begin
          bcnt_next = bcnt + BCNT_ONE;
        end
      end

      ST_STOP: begin
        // Leave at mid-stop-bit so a slightly fast host can start the next
        // frame before our notion of the stop bit has ended.
        if (decide) begin
          bcnt_next  = '0;
          state_next = vote_bit ? ST_IDLE : ST_BREAK;
        end else begin
          bcnt_next = bcnt + BCNT_ONE;
        end
      end

      ST_BREAK: begin
        // A line held low must return high before a new start is armed.
        bcnt_next = '0;
        if (rx) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        bcnt_next  = '0;
        bidx_next  = 3'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode and buffer handshake
  // --------------------------------------------------------------------------
  always_comb begin
    shift_en     = 1'b0;
    byte_done    = 1'b0;
    frame_bad    = 1'b0;

    if (decide) begin
      case (state)
        ST_DATA: shift_en = 1'b1;
        ST_STOP: begin
          byte_done = vote_bit;
          frame_bad = ~vote_bit;
        end
        default: begin
          shift_en = 1'b0;
        end
      endcase
    end

    // A read in the same cycle as a completing byte frees the slot in time
    // for the new byte, so only an unread full buffer drops data.
    take = i_read & o_valid;
    load = byte_done & (~o_valid | i_read);
    drop = byte_done & o_valid & ~i_read;

    if (load) begin
      valid_next = 1'b1;
    end else if (take) begin
      valid_next = 1'b0;
    end else begin
      valid_next = o_valid;
    end

    // Setting has priority over the clear caused by a read.
    if (drop) begin
      overrun_next = 1'b1;
    end else if (take) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = o_overrun;
    end
  end

  // --------------------------------------------------------------------------
  // Data path: shift register (LSB first) and output buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg <= 8'h00;
    end else if (shift_en) begin
      shreg <= {vote_bit, shreg[7:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dat          <= 8'h00;
      o_valid        <= 1'b0;
      o_frame_err    <= 1'b0;
      o_overrun      <= 1'b0;
      o_serial_cts_n <= 1'b1;
    end else begin
      if (load) begin
        o_dat <= shreg;
      end
      o_valid        <= valid_next;
      o_frame_err    <= frame_bad;
      o_overrun      <= overrun_next;
      // Tracks the buffer so the host is told to hold off on the same edge
      // the byte becomes visible.
      o_serial_cts_n <= valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trng_com_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_trng_com_rx
// Purpose  : Self-checking bench for trng_com_rx. Frames are driven bit by
//            bit on the serial line; a frame-level model of the one-entry
//            buffer predicts o_dat / o_valid / o_overrun / o_serial_cts_n and
//            the arrival edge is predicted from the frame start arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_com_rx;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  // Edges from first low drive to o_valid: 2 synchroniser edges, the IDLE
  // detection edge, then 9 full bits plus H+2 into the stop bit.
  localparam int LAT = 3 + 9 * CPB + H + 2;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic       rd;
  logic [7:0] dat;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       cts_n;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Frame-level reference model of the buffer.
  logic [7:0] exp_dat;
  logic       exp_valid;
  logic       exp_ovr;

  // Event log filled by the monitor.
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  int   ferr_cnt = 0;
  int   ferr_cyc = 0;
  logic prev_valid = 1'b0;

  trng_com_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_serial_data  (serial),
    .i_read         (rd),
    .o_dat          (dat),
    .o_valid        (valid),
    .o_frame_err    (ferr),
    .o_overrun      (ovr),
    .o_serial_cts_n (cts_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (valid && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = valid;
    if (ferr) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Model
  // --------------------------------------------------------------------------
  task automatic model_reset();
    exp_dat   = 8'h00;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic model_complete(input logic [7:0] b, input bit read_now);
    if (exp_valid && !read_now) begin
      exp_ovr = 1'b1;
    end else begin
      if (exp_valid) exp_ovr = 1'b0;
      exp_dat   = b;
      exp_valid = 1'b1;
    end
  endtask

  task automatic model_read();
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // --------------------------------------------------------------------------
  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Drives the first nbits bits of {stop, d, start}. With corrupt set, each
  // data bit is inverted for the one cycle the receiver samples at bcnt=H.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input bit corrupt, input int nbits, output int n);
    logic [9:0] bits;
    bits = {stop_ok, d, 1'b0};
    n = cyc;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        serial = bits[b] ^ (corrupt && b >= 1 && b <= 8 && c == H + 1);
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    model_read();
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n  = 1'b0;
    serial = 1'b1;
    rd     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (dat !== 8'h00) begin bad++; $display("FAIL reset_dat got=%h exp=00", dat); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
    total++; if (cts_n !== 1'b1) begin bad++; $display("FAIL reset_cts got=%b exp=1", cts_n); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (cts_n !== 1'b0) begin bad++; $display("FAIL reset_cts_release got=%b exp=0", cts_n); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] b;
    int n;
    int r0;
    int f0;
    for (int i = 0; i < 4; i++) begin
      b  = (i == 0) ? 8'hA5 : 8'($urandom);
      r0 = rise_cnt;
      f0 = ferr_cnt;
      send_frame(b, 1'b1, 1'b0, 10, n);
      model_complete(b, 1'b0);
      total++; if (rise_cyc !== n + LAT || rise_cnt !== r0 + 1) begin
        bad++; $display("FAIL single_time got=%0d/%0d exp=%0d/%0d", rise_cyc - n, rise_cnt - r0, LAT, 1);
      end
      total++; if (dat !== exp_dat || valid !== exp_valid) begin
        bad++; $display("FAIL single_data got=%h/%b exp=%h/%b", dat, valid, exp_dat, exp_valid);
      end
      total++; if (cts_n !== exp_valid || ovr !== exp_ovr || ferr_cnt !== f0) begin
        bad++; $display("FAIL single_flags got cts=%b ovr=%b ferr=%0d exp cts=%b ovr=%b ferr=%0d",
                        cts_n, ovr, ferr_cnt - f0, exp_valid, exp_ovr, 0);
      end
      pulse_read();
      total++; if (valid !== exp_valid || cts_n !== exp_valid) begin
        bad++; $display("FAIL single_read got=%b/%b exp=%b/%b", valid, cts_n, exp_valid, exp_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    int n0;
    int r0;
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
    n0 = cyc;
    r0 = rise_cnt;
    fork
      begin
        int n;
        for (int k = 0; k < 3; k++) send_frame(seq[k], 1'b1, 1'b0, 10, n);
      end
      begin
        wait_until(n0 + LAT);
        model_complete(seq[0], 1'b0);
        total++; if (dat !== exp_dat || valid !== exp_valid) begin
          bad++; $display("FAIL b2b_first got=%h/%b exp=%h/%b", dat, valid, exp_dat, exp_valid);
        end
        // Read the first byte on exactly the edge the second one completes.
        wait_until(n0 + FRAME + LAT - 1);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        model_complete(seq[1], 1'b1);
        total++; if (dat !== exp_dat || valid !== exp_valid || ovr !== exp_ovr || cts_n !== exp_valid) begin
          bad++; $display("FAIL b2b_same_cycle got=%h/%b/%b/%b exp=%h/%b/%b/%b",
                          dat, valid, ovr, cts_n, exp_dat, exp_valid, exp_ovr, exp_valid);
        end
        pulse_read();
        total++; if (valid !== exp_valid) begin
          bad++; $display("FAIL b2b_read2 got=%b exp=%b", valid, exp_valid);
        end
        wait_until(n0 + 2 * FRAME + LAT);
        model_complete(seq[2], 1'b0);
        total++; if (dat !== exp_dat || valid !== exp_valid) begin
          bad++; $display("FAIL b2b_third got=%h/%b exp=%h/%b", dat, valid, exp_dat, exp_valid);
        end
        pulse_read();
      end
    join
    total++; if (ovr !== exp_ovr || rise_cnt !== r0 + 2 || valid !== exp_valid) begin
      bad++; $display("FAIL b2b_end got ovr=%b rises=%0d valid=%b exp ovr=%b rises=2 valid=%b",
                      ovr, rise_cnt - r0, valid, exp_ovr, exp_valid);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] a;
    logic [7:0] b;
    int n;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 8'h11 : 8'($urandom);
      b = (i == 0) ? 8'h22 : 8'($urandom);
      send_frame(a, 1'b1, 1'b0, 10, n);
      model_complete(a, 1'b0);
      send_frame(b, 1'b1, 1'b0, 10, n);
      model_complete(b, 1'b0);
      total++; if (dat !== exp_dat || valid !== exp_valid || ovr !== exp_ovr) begin
        bad++; $display("FAIL overrun_set got=%h/%b/%b exp=%h/%b/%b", dat, valid, ovr, exp_dat, exp_valid, exp_ovr);
      end
      pulse_read();
      total++; if (valid !== exp_valid || ovr !== exp_ovr || cts_n !== exp_valid) begin
        bad++; $display("FAIL overrun_clear got=%b/%b/%b exp=%b/%b/%b", valid, ovr, cts_n, exp_valid, exp_ovr, exp_valid);
      end
    end
  endtask

  task automatic test_frame_err();
    int n;
    int n2;
    int r0;
    int f0;
    r0 = rise_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 10, n);
    repeat (40) @(negedge clk);
    serial = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (ferr_cnt !== f0 + 1 || ferr_cyc !== n + LAT) begin
      bad++; $display("FAIL ferr_pulse got=%0d@%0d exp=1@%0d", ferr_cnt - f0, ferr_cyc - n, LAT);
    end
    total++; if (rise_cnt !== r0 || valid !== exp_valid) begin
      bad++; $display("FAIL ferr_no_valid got rises=%0d valid=%b exp rises=0 valid=%b", rise_cnt - r0, valid, exp_valid);
    end
    send_frame(8'h66, 1'b1, 1'b0, 10, n2);
    model_complete(8'h66, 1'b0);
    total++; if (dat !== exp_dat || valid !== exp_valid || rise_cyc !== n2 + LAT || ferr_cnt !== f0 + 1) begin
      bad++; $display("FAIL ferr_next got=%h/%b@%0d ferr=%0d exp=%h/%b@%0d ferr=1",
                      dat, valid, rise_cyc - n2, ferr_cnt - f0, exp_dat, exp_valid, LAT);
    end
    pulse_read();
  endtask

  task automatic test_glitch_vote();
    logic [7:0] b;
    int n;
    int r0;
    int f0;
    r0 = rise_cnt;
    f0 = ferr_cnt;
    serial = 1'b0;
    @(negedge clk);
    serial = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++; if (rise_cnt !== r0 || ferr_cnt !== f0 || valid !== exp_valid) begin
      bad++; $display("FAIL glitch got rises=%0d ferr=%0d valid=%b exp 0/0/%b", rise_cnt - r0, ferr_cnt - f0, valid, exp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      b = (i == 0) ? 8'h81 : 8'($urandom);
      send_frame(b, 1'b1, 1'b1, 10, n);
      model_complete(b, 1'b0);
      total++; if (dat !== exp_dat || valid !== exp_valid || rise_cyc !== n + LAT) begin
        bad++; $display("FAIL vote got=%h/%b@%0d exp=%h/%b@%0d", dat, valid, rise_cyc - n, exp_dat, exp_valid, LAT);
      end
      pulse_read();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p;
    int n;
    int f0;
    // Leave a byte and an overrun pending so the reset has state to clear.
    send_frame(8'($urandom), 1'b1, 1'b0, 10, n);
    send_frame(8'($urandom), 1'b1, 1'b0, 10, n);
    p  = 8'($urandom);
    f0 = ferr_cnt;
    send_frame(p, 1'b1, 1'b0, 5, n);
    serial = p[4];
    repeat (H) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (dat !== exp_dat || valid !== exp_valid || ovr !== exp_ovr || ferr !== 1'b0 || cts_n !== 1'b1) begin
      bad++; $display("FAIL midreset got=%h/%b/%b/%b/%b exp=%h/%b/%b/0/1", dat, valid, ovr, ferr, cts_n, exp_dat, exp_valid, exp_ovr);
    end
    @(negedge clk);
    serial = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0, 10, n);
    model_complete(8'hC3, 1'b0);
    total++; if (dat !== exp_dat || valid !== exp_valid || ovr !== exp_ovr || rise_cyc !== n + LAT || ferr_cnt !== f0) begin
      bad++; $display("FAIL midreset_next got=%h/%b/%b@%0d ferr=%0d exp=%h/%b/%b@%0d ferr=0",
                      dat, valid, ovr, rise_cyc - n, ferr_cnt - f0, exp_dat, exp_valid, exp_ovr, LAT);
    end
    pulse_read();
    total++; if (valid !== exp_valid || cts_n !== exp_valid) begin
      bad++; $display("FAIL midreset_read got=%b/%b exp=%b/%b", valid, cts_n, exp_valid, exp_valid);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    serial = 1'b1;
    rd     = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch_vote();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
